shift_sequencer: RTL and testbench
==================================

SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 SHALL have parameter N, default 8, data width; power of two, >= 4.
REQ-002 SHALL have parameter AMT_W, default 8, width of the requested total shift amount.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  command valid.
REQ-006 SHALL have port in_ready  output  1  command accepted when in_valid && in_ready at a rising edge.
REQ-007 SHALL have port in_data  input  N  operand.
REQ-008 SHALL have port in_amount  input  AMT_W  total logical shift amount, 0 .. 2**AMT_W-1.
REQ-009 SHALL have port in_direction  input  1  0 = right, 1 = left (same encoding as the downstream barrel shifter).
REQ-010 SHALL have port out_valid  output  1  result valid.
REQ-011 SHALL have port out_ready  input  1  result consumed when out_valid && out_ready at a rising edge.
REQ-012 SHALL have port out_data  output  N  shifted result.
REQ-013 SHALL have port busy  output  1  high whenever state != IDLE.

Function
REQ-014 SHALL perform a logical (zero-fill) shift of in_data by in_amount in in_direction; any amount >= N yields all zeros.
REQ-015 SHALL use an FSM with states IDLE, SHIFT, DONE; in_ready = (state == IDLE).
REQ-016 On accept in IDLE: SHALL register operand, direction, and remaining = in_amount; go to DONE if in_amount == 0, else go to SHIFT.
REQ-017 In SHIFT, each cycle: step = min(remaining, N-1); data shifted by step (via the combinational step shifter); remaining -= step; go to DONE when the new remaining == 0.
REQ-018 Latency from the accept edge to out_valid high SHALL be 1 edge for amount 0 and 1 + ceil(amount/(N-1)) edges otherwise.
REQ-019 In DONE: out_valid = 1; out_data SHALL hold stable until out_ready; on handshake go to IDLE.
REQ-020 SHALL NOT accept a new command in the cycle the result is consumed; in_ready rises the following cycle.
REQ-021 out_data SHALL read 0 when out_valid is low.
REQ-022 in_data, in_amount, and in_direction changes SHALL be ignored outside the accept edge.

Reset
REQ-023 rst_n low SHALL immediately force state = IDLE, remaining = 0, data register = 0, out_valid = 0, busy = 0, out_data = 0, and in_ready = 1 after release.
REQ-024 Reset asserted mid-SHIFT or in DONE SHALL abort the command silently; no result is produced after release.

Configuration
REQ-025 With SHIFT_SEQ_EARLY_ZERO_EN defined: an accepted command with in_amount >= N SHALL go directly to DONE with data = 0 (latency 1 edge).
REQ-026 Without SHIFT_SEQ_EARLY_ZERO_EN: such commands SHALL iterate per REQ-017; the result is still 0.

Structure
REQ-027 Package shift_seq_pkg SHALL hold the state enum (IDLE, SHIFT, DONE), the direction enum (DIR_RIGHT = 0, DIR_LEFT = 1), and the step-size function min(remaining, N-1).
REQ-028 Sub-module shift_step_comb SHALL be a purely combinational N-bit logical shifter (data, step[$clog2(N)-1:0], direction -> result), instantiated once.

Verification (N = 8, AMT_W = 8)
REQ-029 Test 1: accept 0xB4, amount 3, right -> out_valid 2 edges after accept, out_data = 0x16.
REQ-030 Test 2: accept 0x01, amount 7, left -> out_data = 0x80 after 2 edges; accept 0x81, amount 0 -> out_data = 0x81 after 1 edge.
REQ-031 Test 3: accept 0xFF, amount 9, right, without the macro -> SHIFT steps of 7 then 2; out_valid after 3 edges; out_data = 0x00.
REQ-032 Test 4: hold out_ready low 5 cycles in DONE -> out_valid and out_data stable; in_ready = 0 throughout; in_ready = 1 one cycle after the handshake.
REQ-033 Test 5: assert rst_n mid-SHIFT on amount 200 -> all outputs 0 immediately; after release no out_valid appears and in_ready = 1.
REQ-034 Test 6: amount 200, left -> 30 edges to out_valid without SHIFT_SEQ_EARLY_ZERO_EN, 1 edge with it; out_data = 0x00 in both cases.

Source files
------------

// File: rtl/shift_seq_pkg.sv
// Shared types and step-size helper for the iterative shift sequencer.
package shift_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef enum logic {
    DIR_RIGHT = 1'b0,
    DIR_LEFT  = 1'b1
  } dir_t;

  function automatic int unsigned step_size(input int unsigned remaining, input int unsigned n);
    return (remaining < n - 1) ? remaining : n - 1;
  endfunction

endpackage

// File: rtl/shift_step_comb.sv
// Combinational N-bit logical (zero-fill) shifter by 0..N-1 positions.
module shift_step_comb
  import shift_seq_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0]         data,
  input  logic [$clog2(N)-1:0] step,
  input  dir_t                 direction,
  output logic [N-1:0]         result
);

  always_comb begin
    result = '0;
    if (direction == DIR_LEFT) result = data << step;
    else                       result = data >> step;
  end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle logical shifter: large amounts are applied in steps of at most N-1.
// Optional macro SHIFT_SEQ_EARLY_ZERO_EN: amounts >= N complete in one edge with zero data.
module shift_sequencer
  import shift_seq_pkg::*;
#(
  parameter int unsigned N     = 8,
  parameter int unsigned AMT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_data,
  input  logic [AMT_W-1:0] in_amount,
  input  logic             in_direction,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_data,
  output logic             busy
);

  localparam int unsigned STEP_W = $clog2(N);

  state_t           state_q, state_d;
  logic [N-1:0]     data_q, data_d;
  dir_t             dir_q, dir_d;
  logic [AMT_W-1:0] rem_q, rem_d;
  logic [STEP_W-1:0] step;
  logic [N-1:0]     shifted;

  shift_step_comb #(.N(N)) u_step (
    .data      (data_q),
    .step      (step),
    .direction (dir_q),
    .result    (shifted)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      dir_q   <= DIR_RIGHT;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      dir_q   <= dir_d;
      rem_q   <= rem_d;
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    dir_d   = dir_q;
    rem_d   = rem_q;
    step    = STEP_W'(step_size(32'(rem_q), N));
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          data_d = in_data;
          dir_d  = dir_t'(in_direction);
          rem_d  = in_amount;
          if (in_amount == '0) state_d = DONE;
          else                 state_d = SHIFT;
`ifdef SHIFT_SEQ_EARLY_ZERO_EN
          if (32'(in_amount) >= 32'(N)) begin
            data_d  = '0;
            rem_d   = '0;
            state_d = DONE;
          end
`endif
        end
      end
      SHIFT: begin
        data_d = shifted;
        rem_d  = rem_q - AMT_W'(step);
        if (rem_d == '0) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == DONE);
  assign out_data  = out_valid ? data_q : '0;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed self-checking bench for shift_sequencer (N=8, AMT_W=8).
module tb_shift_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [7:0] in_amount;
  logic       in_direction;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       busy;

  int errors = 0;
  int checks = 0;
  int lat;
  bit seen_valid;

`ifdef SHIFT_SEQ_EARLY_ZERO_EN
  localparam int LAT_AMT9   = 1;
  localparam int LAT_AMT200 = 1;
`else
  localparam int LAT_AMT9   = 3;
  localparam int LAT_AMT200 = 30;
`endif

  shift_sequencer #(.N(8), .AMT_W(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_amount    (in_amount),
    .in_direction (in_direction),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one command, scramble inputs after the accept edge, count edges to out_valid.
  task automatic run_cmd(input logic [7:0] d, input logic [7:0] amt, input logic dir,
                         output int edges);
    chk("pre_accept_ready", {31'd0, in_ready}, 32'd1);
    in_valid     = 1'b1;
    in_data      = d;
    in_amount    = amt;
    in_direction = dir;
    @(posedge clk); #1;
    in_valid     = 1'b0;
    in_data      = 8'($urandom);
    in_amount    = 8'($urandom);
    in_direction = 1'($urandom);
    edges = 1;
    while (!out_valid && edges < 100) begin
      @(posedge clk); #1;
      edges++;
    end
  endtask

  task automatic consume();
    chk("ready_in_done", {31'd0, in_ready}, 32'd0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("ready_after_hs", {31'd0, in_ready}, 32'd1);
    chk("valid_after_hs", {31'd0, out_valid}, 32'd0);
    chk("data_after_hs", {24'd0, out_data}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_amount = '0;
    in_direction = 1'b0; out_ready = 1'b0;
    #1;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_data", {24'd0, out_data}, 32'd0);
    chk("rst_ready", {31'd0, in_ready}, 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Test 1: 0xB4 >> 3
    run_cmd(8'hB4, 8'd3, 1'b0, lat);
    chk("t1_lat", 32'(lat), 32'd2);
    chk("t1_data", {24'd0, out_data}, 32'h16);
    consume();

    // Test 2: 0x01 << 7, then 0x81 with amount 0
    run_cmd(8'h01, 8'd7, 1'b1, lat);
    chk("t2a_lat", 32'(lat), 32'd2);
    chk("t2a_data", {24'd0, out_data}, 32'h80);
    consume();
    run_cmd(8'h81, 8'd0, 1'b1, lat);
    chk("t2b_lat", 32'(lat), 32'd1);
    chk("t2b_data", {24'd0, out_data}, 32'h81);
    consume();

    // Test 3: 0xFF >> 9
    run_cmd(8'hFF, 8'd9, 1'b0, lat);
    chk("t3_lat", 32'(lat), 32'(LAT_AMT9));
    chk("t3_data", {24'd0, out_data}, 32'h00);
    consume();

    // Test 4: stall in DONE for 5 cycles on 0x3C << 2
    run_cmd(8'h3C, 8'd2, 1'b1, lat);
    chk("t4_lat", 32'(lat), 32'd2);
    for (int i = 0; i < 5; i++) begin
      chk("t4_valid_hold", {31'd0, out_valid}, 32'd1);
      chk("t4_data_hold", {24'd0, out_data}, 32'hF0);
      chk("t4_ready_low", {31'd0, in_ready}, 32'd0);
      @(posedge clk); #1;
    end
    consume();

    // Test 5: reset in the middle of a long SHIFT
    in_valid = 1'b1; in_data = 8'hA5; in_amount = 8'd200; in_direction = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("t5_busy_mid", {31'd0, busy}, 32'd1);
    chk("t5_data_mid", {24'd0, out_data}, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("t5_rst_busy", {31'd0, busy}, 32'd0);
    chk("t5_rst_data", {24'd0, out_data}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen_valid = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) seen_valid = 1'b1;
    end
    chk("t5_no_result", {31'd0, seen_valid}, 32'd0);
    chk("t5_ready", {31'd0, in_ready}, 32'd1);

    // Test 6: 0xFF << 200
    run_cmd(8'hFF, 8'd200, 1'b1, lat);
    chk("t6_lat", 32'(lat), 32'(LAT_AMT200));
    chk("t6_data", {24'd0, out_data}, 32'h00);
    consume();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
